// File: rtl/reg_file_sb.sv
// reg_file_sb: parametrised register file with a pending-write scoreboard
// and a post-reset sequential clear engine (one entry per cycle, from 1 up).
//
// Parameters: DATA_W (register width), ADDR_W (address width, DEPTH=2**ADDR_W).
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   ready               high once the clear sweep has finished
//   rs_addr/rs_data/rs_busy, rt_addr/rt_data/rt_busy
//                       two combinational read ports (data + pending flag)
//   wr_en/wr_addr/wr_data      writeback port, clears busy
//   claim_en/claim_addr        issue-stage claim, sets busy
//   pend_cnt            registered count of busy registers
// Optional build macro: RF_BYPASS_EN forwards same-cycle writeback data to
// the read ports and masks their busy flags.
module reg_file_sb #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  output logic              ready,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic              rs_busy,
  output logic              rt_busy,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              claim_en,
  input  logic [ADDR_W-1:0] claim_addr,
  output logic [ADDR_W:0]   pend_cnt
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] ptr, ptr_next;
  logic              ready_next;
  logic [DEPTH-1:0]  busy, busy_next;
  logic [CNT_W-1:0]  pend_next;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem [DEPTH];

  // State, sweep pointer and scoreboard registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= CLEAR;
      ptr      <= ADDR_W'(1);
      ready    <= 1'b0;
      busy     <= '0;
      pend_cnt <= '0;
    end else begin
      state    <= state_next;
      ptr      <= ptr_next;
      ready    <= ready_next;
      busy     <= busy_next;
      pend_cnt <= pend_next;
    end
  end

  // Storage array kept free of reset so it can map onto a RAM macro
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // Next-state, sweep control, write port and busy-bit update
  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    ready_next = ready;
    busy_next  = busy;
    mem_we     = 1'b0;
    mem_waddr  = ptr;
    mem_wdata  = '0;
    case (state)
      CLEAR: begin
        mem_we   = 1'b1;
        ptr_next = ptr + ADDR_W'(1);
        if (ptr == ADDR_W'(DEPTH - 1)) begin
          state_next = RUN;
          ready_next = 1'b1;
        end
      end
      RUN: begin
        if (wr_en && (wr_addr != '0)) begin
          mem_we             = 1'b1;
          mem_waddr          = wr_addr;
          mem_wdata          = wr_data;
          busy_next[wr_addr] = 1'b0;
        end
        // Claim applied after the write so a same-address claim wins
        if (claim_en && (claim_addr != '0)) busy_next[claim_addr] = 1'b1;
      end
      default: state_next = CLEAR;
    endcase
    if (reset) mem_we = 1'b0;
  end

  // Pending count registered from the next busy vector
  always_comb begin
    pend_next = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      pend_next = pend_next + CNT_W'(busy_next[i]);
    end
  end

  // Read ports: zero while clearing and for entry 0
  always_comb begin
    rs_data = '0;
    rs_busy = 1'b0;
    rt_data = '0;
    rt_busy = 1'b0;
    if (state == RUN) begin
      if (rs_addr != '0) begin
        rs_data = mem[rs_addr];
        rs_busy = busy[rs_addr];
`ifdef RF_BYPASS_EN
        if (wr_en && (wr_addr == rs_addr)) begin
          rs_data = wr_data;
          rs_busy = 1'b0;
        end
`endif
      end
      if (rt_addr != '0) begin
        rt_data = mem[rt_addr];
        rt_busy = busy[rt_addr];
`ifdef RF_BYPASS_EN
        if (wr_en && (wr_addr == rt_addr)) begin
          rt_data = wr_data;
          rt_busy = 1'b0;
        end
`endif
      end
    end
  end

endmodule
